// File: rtl/dmem_arbiter.sv
// dmem_arbiter: lets the DSP core (port 0) and the DMA/host loader (port 1)
// share a single-port data memory. Round-robin arbitration with a bounded burst.
//
// Ports:
//   clk, rst           clock and asynchronous active-high reset
//   reqN/weN/addrN     per-requester access request, write flag and address
//   wdataN             per-requester write data
//   gntN               combinational grant for the current cycle
//   rvalidN/rdataN     read data return, one cycle after the read grant
//   mem_*              memory strobe, write enable, address, write data, read data
module dmem_arbiter #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int RUN_W = $clog2(BURST_MAX + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(BURST_MAX);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

  logic             r_last;
  logic             r_prev_act;
  logic [RUN_W-1:0] r_run;
  logic [1:0]       r_rd_pend;

  logic w_keep;
  logic w_pick1;
  logic w_g0;
  logic w_g1;
  logic w_any;
  logic w_same;

  // On contention the previous owner keeps the memory only while its
  // burst is unbroken (no idle cycle) and still below the limit.
  always_comb begin
    w_keep  = r_prev_act && (r_run < RUN_MAX);
    w_pick1 = w_keep ? r_last : ~r_last;
    w_g0    = ~rst & req0 & (~req1 | ~w_pick1);
    w_g1    = ~rst & req1 & (~req0 | w_pick1);
    w_any   = w_g0 | w_g1;
    w_same  = r_prev_act && (w_g1 == r_last);
  end

  assign gnt0 = w_g0;
  assign gnt1 = w_g1;
  assign mem_en = w_any;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (1'b1)
      w_g0: begin
        mem_we    = we0;
        mem_addr  = addr0;
        mem_wdata = wdata0;
      end
      w_g1: begin
        mem_we    = we1;
        mem_addr  = addr1;
        mem_wdata = wdata1;
      end
      default: begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last     <= 1'b1;
      r_prev_act <= 1'b0;
      r_run      <= '0;
      r_rd_pend  <= '0;
    end else begin
      r_rd_pend[0] <= w_g0 & ~we0;
      r_rd_pend[1] <= w_g1 & ~we1;
      if (w_any) begin
        r_last     <= w_g1;
        r_prev_act <= 1'b1;
        if (w_same) begin
          if (r_run != RUN_MAX) begin
            r_run <= r_run + RUN_ONE;
          end
        end else begin
          r_run <= RUN_ONE;
        end
      end else begin
        r_prev_act <= 1'b0;
        r_run      <= '0;
      end
    end
  end

  assign rvalid0 = r_rd_pend[0];
  assign rvalid1 = r_rd_pend[1];
  assign rdata0  = mem_rdata;
  assign rdata1  = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized and directed bench for dmem_arbiter.
// Reference: grant history queue plus a word-array memory image.
module tb_dmem_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int B  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] mem     [0:1023];
  logic [DW-1:0] ref_mem [0:1023];

  int            hist[$];
  logic          exp_rv0, exp_rv1;
  logic [DW-1:0] exp_rd;

  dmem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .BURST_MAX(B)
  ) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous single-port memory the arbiter drives.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else mem_rdata <= mem[mem_addr];
    end
  end

  // Grant rule derived from the history of grants since reset:
  // the previous owner keeps the memory only while its unbroken
  // streak of grants is shorter than B.
  function automatic int model_grant(input logic r0, input logic r1);
    int lst, n, top;
    if (!r0 && !r1) return -1;
    if (r0 && !r1) return 0;
    if (!r0 && r1) return 1;
    lst = 1;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != -1) begin
        lst = hist[i];
        break;
      end
    end
    if (hist.size() == 0) return 1 - lst;
    top = hist[hist.size() - 1];
    if (top == -1) return 1 - lst;
    n = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != top) break;
      n++;
    end
    return (n < B) ? top : 1 - top;
  endfunction

  task automatic drive(input logic r0, input logic w0,
                       input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic r1, input logic w1,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
  endtask

  // Advance one clock and update the reference with grant g.
  task automatic commit(input int g);
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    w = (g == 0) ? we0 : we1;
    a = (g == 0) ? addr0 : addr1;
    d = (g == 0) ? wdata0 : wdata1;
    @(posedge clk);
    hist.push_back(g);
    exp_rv0 = (g == 0) && !w;
    exp_rv1 = (g == 1) && !w;
    if (g >= 0) begin
      if (w) ref_mem[a] = d;
      else exp_rd = ref_mem[a];
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    hist.delete();
    exp_rv0 = 1'b0;
    exp_rv1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    hist.delete();
    drive(1, 0, 10'd3, 32'h1, 1, 1, 10'd4, 32'h2);
    repeat (2) @(posedge clk);
    #3;
    n_checks++;
    if ({gnt0, gnt1, mem_en, mem_we} !== 4'b0) begin
      n_fail++;
      $display("FAIL rst_gnt got %b exp 0000", {gnt0, gnt1, mem_en, mem_we});
    end
    n_checks++;
    if ({rvalid0, rvalid1} !== 2'b0) begin
      n_fail++;
      $display("FAIL rst_rvalid got %b exp 00", {rvalid0, rvalid1});
    end
    n_checks++;
    if (mem_addr !== '0 || mem_wdata !== '0) begin
      n_fail++;
      $display("FAIL rst_bus got %h/%h exp 0/0", mem_addr, mem_wdata);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_rv0 = 1'b0;
    exp_rv1 = 1'b0;
    drive(1, 0, 10'd3, 32'h1, 1, 0, 10'd4, 32'h2);
    #2;
    n_checks++;
    if ({gnt0, gnt1} !== 2'b10) begin
      n_fail++;
      $display("FAIL rst_first got %b exp 10", {gnt0, gnt1});
    end
    commit(0);
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    commit(-1);
  endtask

  task automatic test_single_read();
    do_reset();
    drive(0, 0, '0, '0, 1, 1, 10'd5, 32'hDEADBEEF);
    #2;
    n_checks++;
    if (gnt1 !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 10'd5) begin
      n_fail++;
      $display("FAIL sr_wr got g%b we%b a%h exp g1 we1 a5", gnt1, mem_we, mem_addr);
    end
    commit(1);
    drive(1, 0, 10'd5, '0, 0, 0, '0, '0);
    #2;
    n_checks++;
    if (gnt0 !== 1'b1 || rvalid1 !== 1'b0 || rvalid0 !== 1'b0) begin
      n_fail++;
      $display("FAIL sr_rd got g0%b rv1%b rv0%b exp 1 0 0", gnt0, rvalid1, rvalid0);
    end
    commit(0);
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    #2;
    n_checks++;
    if (rvalid0 !== 1'b1 || rdata0 !== 32'hDEADBEEF || rvalid1 !== 1'b0) begin
      n_fail++;
      $display("FAIL sr_data got rv0 %b d %h rv1 %b exp 1 deadbeef 0", rvalid0, rdata0, rvalid1);
    end
    commit(-1);
    #2;
    n_checks++;
    if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin
      n_fail++;
      $display("FAIL sr_after got %b%b exp 00", rvalid0, rvalid1);
    end
    commit(-1);
  endtask

  task automatic test_burst();
    int g;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      g = (i / B) % 2;
      drive(1, 0, AW'(i), '0, 1, 0, AW'(i + 1), '0);
      #2;
      n_checks++;
      if ({gnt0, gnt1} !== {g == 0, g == 1}) begin
        n_fail++;
        $display("FAIL burst_gnt cyc %0d got %b exp %0d", i, {gnt0, gnt1}, g);
      end
      n_checks++;
      if ({rvalid0, rvalid1} !== {i > 0 && ((i - 1) / B) % 2 == 0, i > 0 && ((i - 1) / B) % 2 == 1}) begin
        n_fail++;
        $display("FAIL burst_rv cyc %0d got %b", i, {rvalid0, rvalid1});
      end
      if (i > 0) begin
        n_checks++;
        if (rdata0 !== exp_rd) begin
          n_fail++;
          $display("FAIL burst_rd cyc %0d got %h exp %h", i, rdata0, exp_rd);
        end
      end
      commit(g);
    end
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    #2;
    n_checks++;
    if (rvalid1 !== 1'b1 || rvalid0 !== 1'b0 || rdata1 !== exp_rd) begin
      n_fail++;
      $display("FAIL burst_tail got %b%b %h exp 01 %h", rvalid0, rvalid1, rdata1, exp_rd);
    end
    commit(-1);
  endtask

  task automatic test_mid_drop();
    int g;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      g = (i < 2 || i >= 6) ? 0 : 1;
      drive(i != 2, 1, AW'(20 + i), DW'(i), 1, 1, AW'(40 + i), DW'(i));
      #2;
      n_checks++;
      if ({gnt0, gnt1} !== {g == 0, g == 1}) begin
        n_fail++;
        $display("FAIL drop_gnt cyc %0d got %b exp %0d", i, {gnt0, gnt1}, g);
      end
      commit(g);
    end
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    commit(-1);
  endtask

  task automatic test_idle_break();
    do_reset();
    drive(1, 0, 10'd1, '0, 0, 0, '0, '0);
    #2;
    n_checks++;
    if ({gnt0, gnt1} !== 2'b10) begin
      n_fail++;
      $display("FAIL idle_first got %b exp 10", {gnt0, gnt1});
    end
    commit(0);
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    #2;
    n_checks++;
    if (mem_en !== 1'b0 || mem_addr !== '0) begin
      n_fail++;
      $display("FAIL idle_bus got en %b a %h exp 0 0", mem_en, mem_addr);
    end
    commit(-1);
    drive(1, 0, 10'd1, '0, 1, 0, 10'd2, '0);
    #2;
    n_checks++;
    if ({gnt0, gnt1} !== 2'b01) begin
      n_fail++;
      $display("FAIL idle_break got %b exp 01", {gnt0, gnt1});
    end
    commit(1);
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    commit(-1);
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    drive(0, 0, '0, '0, 1, 0, 10'd5, '0);
    #2;
    n_checks++;
    if (gnt1 !== 1'b1) begin
      n_fail++;
      $display("FAIL rmr_gnt got %b exp 1", gnt1);
    end
    #2;
    rst = 1'b1;
    hist.delete();
    exp_rv0 = 1'b0;
    exp_rv1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (rvalid1 !== 1'b0 || gnt1 !== 1'b0) begin
        n_fail++;
        $display("FAIL rmr_rv cyc %0d got rv %b g %b exp 0 0", i, rvalid1, gnt1);
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    drive(1, 0, 10'd6, '0, 1, 0, 10'd7, '0);
    #2;
    n_checks++;
    if ({gnt0, gnt1} !== 2'b10 || rvalid1 !== 1'b0) begin
      n_fail++;
      $display("FAIL rmr_after got %b rv1 %b exp 10 0", {gnt0, gnt1}, rvalid1);
    end
    commit(0);
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    commit(-1);
  endtask

  task automatic test_random();
    int            eg;
    logic          xwe;
    logic [AW-1:0] xa;
    logic [DW-1:0] xd;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) != 0, $urandom % 2, AW'($urandom % 16), $urandom,
            ($urandom % 4) != 0, $urandom % 2, AW'($urandom % 16), $urandom);
      if ($urandom % 8 == 0) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
      #2;
      eg  = model_grant(req0, req1);
      xwe = (eg == 0) ? we0 : (eg == 1) ? we1 : 1'b0;
      xa  = (eg == 0) ? addr0 : (eg == 1) ? addr1 : '0;
      xd  = (eg == 0) ? wdata0 : (eg == 1) ? wdata1 : '0;
      n_checks++;
      if ({gnt0, gnt1, mem_en} !== {eg == 0, eg == 1, eg >= 0}) begin
        n_fail++;
        $display("FAIL rnd_gnt cyc %0d got %b exp grant %0d", i, {gnt0, gnt1, mem_en}, eg);
      end
      n_checks++;
      if (mem_we !== xwe || mem_addr !== xa || mem_wdata !== xd) begin
        n_fail++;
        $display("FAIL rnd_bus cyc %0d got %b %h %h exp %b %h %h", i, mem_we, mem_addr, mem_wdata, xwe, xa, xd);
      end
      n_checks++;
      if ({rvalid0, rvalid1} !== {exp_rv0, exp_rv1}) begin
        n_fail++;
        $display("FAIL rnd_rv cyc %0d got %b exp %b", i, {rvalid0, rvalid1}, {exp_rv0, exp_rv1});
      end
      if (exp_rv0 || exp_rv1) begin
        n_checks++;
        if ((exp_rv0 ? rdata0 : rdata1) !== exp_rd) begin
          n_fail++;
          $display("FAIL rnd_rd cyc %0d got %h exp %h", i, exp_rv0 ? rdata0 : rdata1, exp_rd);
        end
      end
      commit(eg);
    end
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    commit(-1);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    mem_rdata = '0;
    exp_rd = '0;
    exp_rv0 = 1'b0;
    exp_rv1 = 1'b0;
    rst = 1'b1;
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    #1;
    test_reset();
    test_single_read();
    test_burst();
    test_mid_drop();
    test_idle_break();
    test_reset_mid_read();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
